// File: rtl/dist_ram_fifo_ctrl.sv
// FIFO controller for a 16x4 dual-port distributed RAM.
// It keeps 5-bit write/read pointers (MSB is the wrap bit), a level counter and a
// first-word-fall-through output register, so the FIFO holds up to 17 words.
// The RAM is external; this block is its only writer and its only reader.
module dist_ram_fifo_ctrl #(
  parameter int unsigned AF_LEVEL = 12,  // almost_full when level >= AF_LEVEL (1..17)
  parameter int unsigned AE_LEVEL = 2    // almost_empty when level <= AE_LEVEL (0..16)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  // producer side
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_data,
  // consumer side
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [3:0] rd_data,
  // status
  output logic [4:0] level,
  output logic       almost_full,
  output logic       almost_empty,
  output logic       overflow,
  // distributed RAM connection
  output logic       ram_we,
  output logic [3:0] ram_waddr,
  output logic [3:0] ram_raddr,
  output logic [3:0] ram_wdata,
  input  logic [3:0] ram_rdata
);

  localparam logic [4:0] AfLevel  = 5'(AF_LEVEL);
  localparam logic [4:0] AeLevel  = 5'(AE_LEVEL);
  localparam logic [4:0] MaxLevel = 5'd17;

  // state
  logic [4:0] wptr_q, wptr_d;
  logic [4:0] rptr_q, rptr_d;
  logic       rd_valid_q, rd_valid_d;
  logic [3:0] rd_data_q, rd_data_d;
  logic [4:0] level_q, level_d;
  logic       overflow_q, overflow_d;

  // decoded conditions
  logic ram_full;
  logic ram_empty;
  logic wr_accept;
  logic pop;
  logic load;

  // RAM occupancy from the pointer pair; the wrap bit separates full from empty
  always_comb begin
    ram_empty = (wptr_q == rptr_q);
    ram_full  = (wptr_q[3:0] == rptr_q[3:0]) && (wptr_q[4] != rptr_q[4]);
  end

  // Handshake decode; wr_ready is from registers only so it never waits on rd_ready
  always_comb begin
    wr_ready  = !ram_full;
    wr_accept = wr_valid && wr_ready;
    pop       = rd_valid_q && rd_ready;
    // refill the output register whenever it is empty or being drained this cycle
    load      = !ram_empty && (!rd_valid_q || rd_ready);
  end

  // RAM port drive; a flush cycle must not disturb RAM even if a write is offered
  always_comb begin
    ram_we    = wr_accept && !flush;
    ram_waddr = wptr_q[3:0];
    ram_wdata = wr_data;
    ram_raddr = rptr_q[3:0];
  end

  // Next-state: flush wins over everything, then write and read sides proceed independently
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (flush) begin
      wptr_d     = 5'd0;
      rptr_d     = 5'd0;
      rd_valid_d = 1'b0;
      level_d    = 5'd0;
      overflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wptr_d = wptr_q + 5'd1;
      end

      if (load) begin
        rd_data_d  = ram_rdata;
        rd_valid_d = 1'b1;
        rptr_d     = rptr_q + 5'd1;
      end else if (pop) begin
        // drained with nothing behind it; rd_data keeps its stale value
        rd_valid_d = 1'b0;
      end

      unique case ({wr_accept, pop})
        2'b10:   level_d = level_q + 5'd1;
        2'b01:   level_d = level_q - 5'd1;
        default: level_d = level_q;
      endcase

      if (wr_valid && !wr_ready) begin
        overflow_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= 5'd0;
      rptr_q     <= 5'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 4'd0;
      level_q    <= 5'd0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Registered outputs and threshold flags
  always_comb begin
    rd_valid     = rd_valid_q;
    rd_data      = rd_data_q;
    level        = level_q;
    overflow     = overflow_q;
    almost_full  = (level_q >= AfLevel);
    almost_empty = (level_q <= AeLevel);
  end

  // Structural invariants of the pointer/level bookkeeping
  a_level_max: assert property (@(posedge clk) disable iff (!rst_n) level_q <= MaxLevel);
  a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n) !(ram_we && ram_full));
  a_level_match: assert property (@(posedge clk) disable iff (!rst_n)
    level_q == 5'(5'(wptr_q - rptr_q) + {4'd0, rd_valid_q}));

endmodule

// File: tb/tb_dist_ram_fifo_ctrl.sv
// Self-checking bench for dist_ram_fifo_ctrl with a behavioural 16x4 RAM beside it.
// Reference model: a queue for words held in RAM plus a head slot for the output register.
module tb_dist_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] rd_data;
  logic [4:0] level;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       ram_we;
  logic [3:0] ram_waddr;
  logic [3:0] ram_raddr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;

  dist_ram_fifo_ctrl #(
    .AF_LEVEL(12),
    .AE_LEVEL(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .ram_we      (ram_we),
    .ram_waddr   (ram_waddr),
    .ram_raddr   (ram_raddr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  always #5 clk = ~clk;

  // 16x4 distributed RAM: synchronous write, asynchronous read
  logic [3:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 4'd0;
  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  int         mq[$];     // words sitting in RAM, oldest first
  bit         m_hv;      // output register holds a word
  logic [3:0] m_hd;
  bit         m_ovf;
  int         m_wcnt;    // writes since reset/flush (address = mod 16)
  int         m_rcnt;    // loads since reset/flush
  int         last_waddr;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_level();
    return mq.size() + int'(m_hv);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_hv   = 1'b0;
    m_hd   = 4'd0;
    m_ovf  = 1'b0;
    m_wcnt = 0;
    m_rcnt = 0;
  endfunction

  // One clock cycle: drive at negedge, check combinational outputs, clock, check registers
  task automatic step(input bit wv, input logic [3:0] wd, input bit rr, input bit fl);
    bit can_wr, acc, pop_c, load_c;
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
    #1;
    can_wr = (mq.size() < 16);
    acc    = wv && can_wr;
    check("wr_ready", int'(wr_ready), int'(can_wr));
    check("ram_we", int'(ram_we), int'(acc && !fl));
    last_waddr = ram_we ? int'(ram_waddr) : -1;
    if (acc && !fl) begin
      check("ram_waddr", int'(ram_waddr), m_wcnt % 16);
      check("ram_wdata", int'(ram_wdata), int'(wd));
    end
    check("ram_raddr", int'(ram_raddr), m_rcnt % 16);
    @(posedge clk);
    if (fl) begin
      model_reset();
    end else begin
      if (wv && !can_wr) m_ovf = 1'b1;
      pop_c  = m_hv && rr;
      load_c = (mq.size() > 0) && (!m_hv || rr);
      if (load_c) begin
        m_hd = 4'(mq.pop_front());
        m_hv = 1'b1;
        m_rcnt++;
      end else if (pop_c) begin
        m_hv = 1'b0;
      end
      if (acc) begin
        mq.push_back(int'(wd));
        m_wcnt++;
      end
    end
    @(negedge clk);
    check("rd_valid", int'(rd_valid), int'(m_hv));
    if (m_hv) check("rd_data", int'(rd_data), int'(m_hd));
    check("level", int'(level), m_level());
    check("almost_full", int'(almost_full), int'(m_level() >= 12));
    check("almost_empty", int'(almost_empty), int'(m_level() <= 2));
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  typedef struct {
    bit         wv;
    logic [3:0] wd;
    bit         rr;
    int         exp_waddr;  // -1: no RAM write expected
    bit         exp_rv;
    logic [3:0] exp_rd;
    int         exp_lvl;
  } vec_t;

  vec_t vecs[5];
  int   exp_next;

  initial begin
    vecs[0] = '{wv: 1'b1, wd: 4'h1, rr: 1'b0, exp_waddr: 0,  exp_rv: 1'b0, exp_rd: 4'h0, exp_lvl: 1};
    vecs[1] = '{wv: 1'b1, wd: 4'h2, rr: 1'b0, exp_waddr: 1,  exp_rv: 1'b1, exp_rd: 4'h1, exp_lvl: 2};
    vecs[2] = '{wv: 1'b1, wd: 4'h3, rr: 1'b0, exp_waddr: 2,  exp_rv: 1'b1, exp_rd: 4'h1, exp_lvl: 3};
    vecs[3] = '{wv: 1'b0, wd: 4'h0, rr: 1'b0, exp_waddr: -1, exp_rv: 1'b1, exp_rd: 4'h1, exp_lvl: 3};
    vecs[4] = '{wv: 1'b0, wd: 4'h0, rr: 1'b1, exp_waddr: -1, exp_rv: 1'b1, exp_rd: 4'h2, exp_lvl: 2};

    // reset state
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = 4'd0; rd_ready = 1'b0;
    model_reset();
    #12;
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_level", int'(level), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_wr_ready", int'(wr_ready), 1);
    check("rst_almost_empty", int'(almost_empty), 1);
    check("rst_almost_full", int'(almost_full), 0);
    check("rst_ram_we", int'(ram_we), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // table: push 1..3, hold, then one pop
    foreach (vecs[i]) begin
      step(vecs[i].wv, vecs[i].wd, vecs[i].rr, 1'b0);
      check("tbl_waddr", last_waddr, vecs[i].exp_waddr);
      check("tbl_rd_valid", int'(rd_valid), int'(vecs[i].exp_rv));
      if (vecs[i].exp_rv) check("tbl_rd_data", int'(rd_data), int'(vecs[i].exp_rd));
      check("tbl_level", int'(level), vecs[i].exp_lvl);
    end
    while (m_level() > 0) step(1'b0, 4'd0, 1'b1, 1'b0);

    // fill to 17 with 0..F,0, then one extra offer
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 4'(i), 1'b0, 1'b0);
      if (i == 10) check("af_at_11", int'(almost_full), 0);
      if (i == 11) check("af_at_12", int'(almost_full), 1);
    end
    check("full_level", int'(level), 17);
    check("full_wr_ready", int'(wr_ready), 0);
    check("full_ovf_before", int'(overflow), 0);
    step(1'b1, 4'h7, 1'b0, 1'b0);
    check("full_ovf_after", int'(overflow), 1);
    check("full_level_kept", int'(level), 17);

    // drain 17 in order on consecutive cycles
    for (int i = 0; i < 17; i++) begin
      check("drain_valid", int'(rd_valid), 1);
      check("drain_data", int'(rd_data), i % 16);
      step(1'b0, 4'd0, 1'b1, 1'b0);
    end
    check("drain_rd_valid", int'(rd_valid), 0);
    check("drain_level", int'(level), 0);
    check("drain_ae", int'(almost_empty), 1);

    // streaming: 40 words through with both sides always ready
    exp_next = 0;
    for (int i = 0; i < 40; i++) begin
      if (rd_valid) begin
        check("stream_order", int'(rd_data), exp_next % 16);
        exp_next++;
      end
      step(1'b1, 4'(i % 16), 1'b1, 1'b0);
      check("stream_level_1_2", int'(level >= 5'd1 && level <= 5'd2), 1);
    end
    for (int i = 0; i < 4 && rd_valid; i++) begin
      check("stream_order", int'(rd_data), exp_next % 16);
      exp_next++;
      step(1'b0, 4'd0, 1'b1, 1'b0);
    end
    check("stream_count", exp_next, 40);

    // flush at level 9 with a concurrent write; overflow still sticky from earlier
    for (int i = 0; i < 9; i++) step(1'b1, 4'(i + 3), 1'b0, 1'b0);
    check("pre_flush_level", int'(level), 9);
    check("pre_flush_ovf", int'(overflow), 1);
    step(1'b1, 4'h5, 1'b1, 1'b1);
    check("flush_level", int'(level), 0);
    check("flush_rd_valid", int'(rd_valid), 0);
    check("flush_ovf", int'(overflow), 0);
    step(1'b1, 4'hA, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("post_flush_valid", int'(rd_valid), 1);
    check("post_flush_data", int'(rd_data), 10);

    // randomized traffic with phases biased towards filling and draining
    for (int i = 0; i < 600; i++) begin
      bit wv, rr, fl;
      int ph;
      ph = (i / 100) % 3;
      wv = ($urandom_range(0, 3) < (ph == 0 ? 3 : (ph == 1 ? 1 : 2)));
      rr = ($urandom_range(0, 3) < (ph == 0 ? 1 : (ph == 1 ? 3 : 2)));
      fl = ($urandom_range(0, 79) == 0);
      step(wv, 4'($urandom_range(0, 15)), rr, fl);
    end

    // async reset mid-burst after forcing overflow
    for (int i = 0; i < 20; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    check("pre_rst_ovf", int'(overflow), 1);
    wr_valid = 1'b1; wr_data = 4'h9; rd_ready = 1'b1; flush = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_rd_valid", int'(rd_valid), 0);
    check("arst_level", int'(level), 0);
    check("arst_overflow", int'(overflow), 0);
    check("arst_wr_ready", int'(wr_ready), 1);
    wr_valid = 1'b0; rd_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dist_ram_fifo_ctrl.md
Name: dist_ram_fifo_ctrl

Overview:
Single-clock FIFO controller that drives the 16x4 dual-port distributed RAM primitive wrapper. It owns the write/read pointers, full/empty/level tracking and a first-word-fall-through output register. Producers push nibbles through a valid/ready port; consumers pop through a valid/ready port. The RAM sits beside it and is connected via the ram_* ports; this block is its only writer and reader.

Parameters:
AF_LEVEL, 12, almost_full asserts when level >= AF_LEVEL (range 1..17)
AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL (range 0..16)

Ports:
clk  in  1  system clock, rising edge; also drives RAM wclk
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all contents
wr_valid  in  1  producer offers wr_data
wr_ready  out  1  FIFO can accept (RAM not full)
wr_data  in  4  write nibble
rd_valid  out  1  rd_data holds a valid word
rd_ready  in  1  consumer accepts rd_data
rd_data  out  4  head-of-FIFO nibble (registered)
level  out  5  total words held (RAM + output register), 0..17
almost_full  out  1  level >= AF_LEVEL
almost_empty  out  1  level <= AE_LEVEL
overflow  out  1  sticky: wr_valid seen while wr_ready low
ram_we  out  1  RAM write enable
ram_waddr  out  4  RAM write address
ram_raddr  out  4  RAM read address (async read)
ram_wdata  out  4  RAM write data
ram_rdata  in  4  RAM read data (combinational from ram_raddr)

Behaviour:
- Reset (rst_n low, async): wptr=rptr=0 (5-bit, MSB = wrap bit), rd_valid=0, rd_data=0, level=0, overflow=0. Hence wr_ready=1, almost_empty=1, almost_full=0, ram_we=0.
- RAM occupancy: ram_full when wptr[3:0]==rptr[3:0] and wptr[4]!=rptr[4]; ram_empty when wptr==rptr.
- wr_ready = !ram_full (combinational from registers only; never depends on rd_ready).
- Write accept = wr_valid && wr_ready. ram_we = write accept && !flush; ram_waddr=wptr[3:0]; ram_wdata=wr_data (all combinational). wptr += 1 on accept edge; the 5-bit pointer wraps 31->0.
- ram_raddr = rptr[3:0] at all times.
- Output register load condition: !ram_empty && (!rd_valid || rd_ready). On load: rd_data <= ram_rdata, rd_valid <= 1, rptr += 1.
- Pop without load (rd_valid && rd_ready && ram_empty): rd_valid <= 0; rd_data holds its value.
- Latency: a word accepted at edge N into an empty FIFO gives rd_valid=1 after edge N+1. No write-to-read bypass.
- Read/write address collision cannot occur: loads require !ram_empty and writes require !ram_full.
- Simultaneous write accept and pop/load are both honoured in the same cycle.
- level register: +1 on write accept, -1 on pop (rd_valid && rd_ready), unchanged if both or neither. Maximum is 17 (16 in RAM + 1 in register).
- almost_full and almost_empty are combinational compares on level.
- overflow: set on any cycle with wr_valid && !wr_ready; cleared only by flush or reset.
- flush (synchronous, highest priority): next edge wptr=rptr=0, rd_valid=0, level=0, overflow=0. ram_we is forced 0 in the flush cycle and any concurrent write or pop is discarded. RAM contents are don't-care.
- rd_data may be X-free stale when rd_valid=0; the bench must not check it in that state.

Test Plan:
- Reset then push 0x1..0x3 on consecutive cycles with rd_ready=0 -> rd_valid rises one edge after the first accept with rd_data=0x1; level=3; ram_waddr sequence 0,1,2.
- Push 17 words 0x0..0xF,0x0 with rd_ready=0 -> wr_ready falls after the 17th accept; level=17; almost_full high from level 12; an 18th wr_valid sets overflow=1.
- From full, hold rd_ready=1 and wr_valid=0 -> 17 pops in order 0x0..0xF,0x0 on 17 consecutive cycles; then rd_valid=0, level=0, almost_empty=1.
- Continuous push and pop (wr_valid=rd_ready=1) for 40 words 0..F repeating -> output order matches input, level steady at 1-2, pointers wrap past 31 with no gap or duplicate.
- Flush asserted with level=9 and a concurrent wr_valid -> next cycle level=0, rd_valid=0, overflow=0; ram_we=0 in the flush cycle; a subsequent push 0xA reads back 0xA.
- Assert rst_n low asynchronously mid-burst (between edges) -> rd_valid, level and overflow go to 0 immediately without a clock edge; wr_ready=1.
